multi_pulse_extender: RTL and testbench

Multi-channel, run-time-configurable pulse extender for the trigger path. Each channel stretches its input discriminator pulse by a programmable number of clock cycles. Each channel also has a selectable retrigger mode and a programmable dead-time. The block sits between the per-channel FIR threshold comparators and the trigger-coincidence logic, and provides a combined OR output for the global trigger.

---
 rtl/multi_pulse_extender.sv | 106 ++++++++++
 tb/tb_multi_pulse_extender.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_extender.sv
// Multi-channel pulse extender for the trigger path.
// Each channel stretches its input pulse by a programmable number of cycles,
// with optional retriggering and a programmable dead-time after each extension.
// A rising input reaches out in the same cycle; the FSM only supplies the tail.
module multi_pulse_extender #(
  parameter int unsigned N_CHAN    = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CHAN-1:0]    in,
  input  logic [N_CHAN-1:0]    enable,
  input  logic [CNT_WIDTH-1:0] ext_len,
  input  logic [CNT_WIDTH-1:0] deadtime,
  input  logic                 retrig_en,
  output logic [N_CHAN-1:0]    out,
  output logic                 any_out,
  output logic [N_CHAN-1:0]    busy
);

  typedef enum logic [1:0] {StIdle, StHigh, StHold, StDead} state_e;

  // A zero extension length behaves as a single-cycle extension.
  logic [CNT_WIDTH-1:0] ext_len_sat;
  assign ext_len_sat = (ext_len == '0) ? CNT_WIDTH'(1) : ext_len;

  // State that follows the final extension cycle.
  state_e end_state;
  assign end_state = (deadtime != '0) ? StDead : StIdle;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    state_e               state_q;
    logic                 hold_q;
    // cnt_q counts extension cycles in StHold and dead cycles in StDead.
    // lim_q holds the latched N while extending and the latched D while dead.
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] lim_q;

    // Per-channel extension FSM; disabling a channel parks it in StIdle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= StIdle;
        hold_q  <= 1'b0;
        cnt_q   <= '0;
        lim_q   <= '0;
      end else if (!enable[i]) begin
        state_q <= StIdle;
        hold_q  <= 1'b0;
        cnt_q   <= '0;
        lim_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (in[i]) begin
              state_q <= StHigh;
              hold_q  <= 1'b1;
            end
          end
          StHigh: begin
            // First low cycle is extension cycle 1 (hold is still high).
            if (!in[i]) begin
              if (ext_len_sat == CNT_WIDTH'(1)) begin
                state_q <= end_state;
                hold_q  <= 1'b0;
                cnt_q   <= CNT_WIDTH'(1);
                lim_q   <= deadtime;
              end else begin
                state_q <= StHold;
                cnt_q   <= CNT_WIDTH'(2);
                lim_q   <= ext_len_sat;
              end
            end
          end
          StHold: begin
            if (in[i] && retrig_en) begin
              state_q <= StHigh;
              cnt_q   <= '0;
            end else if (cnt_q == lim_q) begin
              state_q <= end_state;
              hold_q  <= 1'b0;
              cnt_q   <= CNT_WIDTH'(1);
              lim_q   <= deadtime;
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end
          StDead: begin
            if (cnt_q == lim_q) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end
        endcase
      end
    end

    // Input passes straight through except while dead; hold supplies the tail.
    assign out[i]  = enable[i] & (hold_q | (in[i] & (state_q != StDead)));
    assign busy[i] = (state_q != StIdle);
  end

  assign any_out = |out;

endmodule

// File: tb/tb_multi_pulse_extender.sv
// Self-checking bench for multi_pulse_extender: directed scenarios plus a
// randomized run against a timestamp-based reference model.
module tb_multi_pulse_extender;

  localparam int NC = 8;
  localparam int CW = 8;

  logic          clk;
  logic          reset_n;
  logic [NC-1:0] in_s;
  logic [NC-1:0] enable_s;
  logic [CW-1:0] ext_len_s;
  logic [CW-1:0] deadtime_s;
  logic          retrig_s;
  logic [NC-1:0] out_w;
  logic          any_w;
  logic [NC-1:0] busy_w;

  int checks   = 0;
  int failures = 0;

  multi_pulse_extender #(
    .N_CHAN    (NC),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in_s),
    .enable    (enable_s),
    .ext_len   (ext_len_s),
    .deadtime  (deadtime_s),
    .retrig_en (retrig_s),
    .out       (out_w),
    .any_out   (any_w),
    .busy      (busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Force every channel to idle with one disabled edge; ends at posedge+1.
  task automatic quiesce();
    in_s     = '0;
    enable_s = '0;
    @(posedge clk);
    #1;
    enable_s = '1;
  endtask

  task automatic test_reset();
    in_s     = 8'hA5;
    enable_s = 8'h3C;
    #1;
    checks++;
    if (out_w !== 8'h24) begin
      failures++;
      $display("FAIL reset_out got=%h exp=%h", out_w, 8'h24);
    end
    checks++;
    if (busy_w !== 8'h00) begin
      failures++;
      $display("FAIL reset_busy got=%h exp=%h", busy_w, 8'h00);
    end
    checks++;
    if (any_w !== 1'b1) begin
      failures++;
      $display("FAIL reset_any got=%b exp=1", any_w);
    end
    in_s     = 8'h00;
    enable_s = 8'hFF;
    #1;
    checks++;
    if (out_w !== 8'h00 || any_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_zero got=%h/%b exp=00/0", out_w, any_w);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_w !== 8'h00 || out_w !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle busy=%h out=%h exp=00/00", busy_w, out_w);
    end
    @(posedge clk);
    #1;
  endtask

  // 3-cycle pulse on ch0, N=6, no dead-time.
  task automatic test_basic();
    logic eo;
    logic eb;
    ext_len_s  = 8'd6;
    deadtime_s = 8'd0;
    retrig_s   = 1'b1;
    quiesce();
    for (int k = 0; k < 13; k++) begin
      in_s = (k <= 2) ? 8'h01 : 8'h00;
      eo   = (k <= 8);
      eb   = (k >= 1 && k <= 8);
      @(negedge clk);
      checks++;
      if (out_w !== {7'b0, eo}) begin
        failures++;
        $display("FAIL basic_out k=%0d got=%h exp=%h", k, out_w, {7'b0, eo});
      end
      checks++;
      if (busy_w !== {7'b0, eb}) begin
        failures++;
        $display("FAIL basic_busy k=%0d got=%h exp=%h", k, busy_w, {7'b0, eb});
      end
      checks++;
      if (any_w !== eo) begin
        failures++;
        $display("FAIL basic_any k=%0d got=%b exp=%b", k, any_w, eo);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses at c0 and c3 on ch1 with N=4 and retriggering on.
  task automatic test_retrig();
    logic eo;
    ext_len_s  = 8'd4;
    deadtime_s = 8'd0;
    retrig_s   = 1'b1;
    quiesce();
    for (int k = 0; k < 11; k++) begin
      in_s = (k == 0 || k == 3) ? 8'h02 : 8'h00;
      eo   = (k <= 7);
      @(negedge clk);
      checks++;
      if (out_w !== {6'b0, eo, 1'b0}) begin
        failures++;
        $display("FAIL retrig_out k=%0d got=%h exp=%h", k, out_w, {6'b0, eo, 1'b0});
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Same pulses without retrigger and D=3; extra pulses at c6 (dead) and c8.
  task automatic test_no_retrig_dead();
    logic eo;
    ext_len_s  = 8'd4;
    deadtime_s = 8'd3;
    retrig_s   = 1'b0;
    quiesce();
    for (int k = 0; k < 17; k++) begin
      in_s = (k == 0 || k == 3 || k == 6 || k == 8) ? 8'h02 : 8'h00;
      eo   = (k <= 4) || (k >= 8 && k <= 12);
      @(negedge clk);
      checks++;
      if (out_w[1] !== eo) begin
        failures++;
        $display("FAIL dead_out k=%0d got=%b exp=%b", k, out_w[1], eo);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ext_len 0 and 1 behave alike; ext_len 255 gives 256 high cycles.
  task automatic test_ext_len_edges();
    logic [CW-1:0] lens [2];
    logic          eo;
    int            high_cnt;
    lens[0]    = 8'd0;
    lens[1]    = 8'd1;
    deadtime_s = 8'd0;
    retrig_s   = 1'b1;
    for (int j = 0; j < 2; j++) begin
      ext_len_s = lens[j];
      quiesce();
      for (int k = 0; k < 5; k++) begin
        in_s = (k == 0) ? 8'h08 : 8'h00;
        eo   = (k <= 1);
        @(negedge clk);
        checks++;
        if (out_w[3] !== eo) begin
          failures++;
          $display("FAIL short_len len=%0d k=%0d got=%b exp=%b", lens[j], k, out_w[3], eo);
        end
        @(posedge clk);
        #1;
      end
    end
    ext_len_s = 8'd255;
    quiesce();
    high_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      in_s = (k == 0) ? 8'h08 : 8'h00;
      eo   = (k <= 255);
      @(negedge clk);
      if (out_w[3] === 1'b1) high_cnt++;
      checks++;
      if (out_w[3] !== eo) begin
        failures++;
        $display("FAIL max_len k=%0d got=%b exp=%b", k, out_w[3], eo);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (high_cnt != 256) begin
      failures++;
      $display("FAIL max_len_count got=%0d exp=256", high_cnt);
    end
  endtask

  // Async reset in the middle of an N=20 extension, then enable drop mid-HOLD.
  task automatic test_async_reset_enable();
    logic eo;
    logic eb;
    ext_len_s  = 8'd20;
    deadtime_s = 8'd0;
    retrig_s   = 1'b1;
    quiesce();
    in_s = 8'h04;
    @(posedge clk);
    #1;
    in_s = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    in_s = 8'h50;
    #1;
    checks++;
    if (out_w !== 8'h54) begin
      failures++;
      $display("FAIL pre_reset_out got=%h exp=%h", out_w, 8'h54);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_w !== 8'h50) begin
      failures++;
      $display("FAIL async_reset_out got=%h exp=%h", out_w, 8'h50);
    end
    checks++;
    if (busy_w !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_busy got=%h exp=00", busy_w);
    end
    @(posedge clk);
    #1;
    in_s    = 8'h00;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 24; k++) begin
      in_s = (k == 0) ? 8'h04 : 8'h00;
      eo   = (k <= 20);
      @(negedge clk);
      checks++;
      if (out_w[2] !== eo) begin
        failures++;
        $display("FAIL after_reset_ext k=%0d got=%b exp=%b", k, out_w[2], eo);
      end
      @(posedge clk);
      #1;
    end
    quiesce();
    for (int k = 0; k < 10; k++) begin
      in_s        = (k == 0) ? 8'h04 : 8'h00;
      enable_s[2] = !(k == 5 || k == 6);
      eo          = (k <= 4);
      eb          = (k >= 1 && k <= 5);
      @(negedge clk);
      checks++;
      if (out_w[2] !== eo) begin
        failures++;
        $display("FAIL enable_out k=%0d got=%b exp=%b", k, out_w[2], eo);
      end
      checks++;
      if (busy_w[2] !== eb) begin
        failures++;
        $display("FAIL enable_busy k=%0d got=%b exp=%b", k, busy_w[2], eb);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Random traffic on all channels against a model built on absolute cycle
  // numbers: when the extension ends and when the dead window ends.
  task automatic test_random();
    bit            trk      [NC];
    int            ext_end  [NC];
    int            dead_end [NC];
    logic [NC-1:0] exp_out;
    logic [NC-1:0] exp_busy;
    bit            in_ext;
    bit            in_dead;
    int            n;
    ext_len_s  = 8'd3;
    deadtime_s = 8'd1;
    retrig_s   = 1'b1;
    quiesce();
    for (int i = 0; i < NC; i++) begin
      trk[i]      = 1'b0;
      ext_end[i]  = -1;
      dead_end[i] = -1;
    end
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NC; i++) begin
        if (in_s[i]) in_s[i] = ($urandom_range(0, 99) < 60);
        else         in_s[i] = ($urandom_range(0, 99) < 15);
        enable_s[i] = ($urandom_range(0, 149) != 0);
      end
      if ($urandom_range(0, 19) == 0) ext_len_s = CW'($urandom_range(0, 10));
      if ($urandom_range(0, 19) == 0) deadtime_s = CW'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) retrig_s = ~retrig_s;

      for (int i = 0; i < NC; i++) begin
        in_dead     = (t <= dead_end[i]);
        in_ext      = !trk[i] && (t <= ext_end[i]);
        exp_busy[i] = trk[i] || in_ext || in_dead;
        exp_out[i]  = enable_s[i] && (trk[i] || in_ext || (in_s[i] && !in_dead));
      end

      @(negedge clk);
      checks++;
      if (out_w !== exp_out) begin
        failures++;
        $display("FAIL rand_out t=%0d got=%h exp=%h", t, out_w, exp_out);
      end
      checks++;
      if (any_w !== (|exp_out)) begin
        failures++;
        $display("FAIL rand_any t=%0d got=%b exp=%b", t, any_w, |exp_out);
      end
      checks++;
      if (busy_w !== exp_busy) begin
        failures++;
        $display("FAIL rand_busy t=%0d got=%h exp=%h", t, busy_w, exp_busy);
      end

      for (int i = 0; i < NC; i++) begin
        in_dead = (t <= dead_end[i]);
        in_ext  = !trk[i] && (t <= ext_end[i]);
        if (!enable_s[i]) begin
          trk[i]      = 1'b0;
          ext_end[i]  = -1;
          dead_end[i] = -1;
        end else if (trk[i]) begin
          if (!in_s[i]) begin
            n          = (ext_len_s == 0) ? 1 : int'(ext_len_s);
            ext_end[i] = t + n - 1;
            trk[i]     = 1'b0;
            if (n == 1) dead_end[i] = t + int'(deadtime_s);
          end
        end else if (in_ext) begin
          if (in_s[i] && retrig_s) begin
            trk[i]     = 1'b1;
            ext_end[i] = -1;
          end else if (t == ext_end[i]) begin
            dead_end[i] = t + int'(deadtime_s);
          end
        end else if (!in_dead && in_s[i]) begin
          trk[i] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    in_s       = '0;
    enable_s   = '1;
    ext_len_s  = 8'd1;
    deadtime_s = 8'd0;
    retrig_s   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_retrig();
    test_no_retrig_dead();
    test_ext_len_edges();
    test_async_reset_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
